// File: rtl/lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// FSM state encoding and the funct3 legality check.
package lsu_pkg;

    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE
    } lsu_state_t;

    // Stores have no unsigned variants, so only B/H/W are legal for them.
    function automatic logic lsu_is_legal(input logic is_store, input logic [2:0] funct3);
        logic ok;
        case (funct3)
            LSU_B, LSU_H, LSU_W: ok = 1'b1;
            LSU_BU, LSU_HU:      ok = !is_store;
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store mask/data replication, load extraction with
// sign/zero extension, and alignment checking for the requested width.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] rdata,
    output logic [3:0]  wmask,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        misaligned
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rdata[{addr_lo, 3'b000} +: 8];
    assign rhalf = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        wmask      = 4'b0000;
        wdata      = store_data;
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b00: begin
                wmask = 4'b0001 << addr_lo;
                wdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                wmask      = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata      = {2{store_data[15:0]}};
                misaligned = addr_lo[0];
            end
            2'b10: begin
                wmask      = 4'b1111;
                misaligned = (addr_lo != 2'b00);
            end
            default: ;
        endcase
    end

    always_comb begin
        load_ext = 32'h0;
        case (funct3)
            LSU_B:   load_ext = {{24{rbyte[7]}}, rbyte};
            LSU_H:   load_ext = {{16{rhalf[15]}}, rhalf};
            LSU_W:   load_ext = rdata;
            LSU_BU:  load_ext = {24'h0, rbyte};
            LSU_HU:  load_ext = {16'h0, rhalf};
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-access stage: latches a request, checks it, runs the
// req/ready handshake with a timeout, and reports completion via done.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal,
    output logic        timeout,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state_q, state_d;
    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] store_data_q;
    logic [CNT_W-1:0] cnt_q;
    logic [31:0] load_data_q;
    logic        illegal_q, misaligned_q, timeout_q;

    logic        in_idle, legal, accept, capture, expire;
    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wmask;
    logic [31:0] al_wdata, al_load_ext;
    logic        al_misaligned;

    // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
    assign in_idle    = (state_q == ST_IDLE);
    assign al_funct3  = in_idle ? funct3    : funct3_q;
    assign al_addr_lo = in_idle ? addr[1:0] : addr_q[1:0];
    assign legal      = lsu_is_legal(is_store, funct3);

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (store_data_q),
        .rdata      (mem_rdata),
        .wmask      (al_wmask),
        .wdata      (al_wdata),
        .load_ext   (al_load_ext),
        .misaligned (al_misaligned)
    );

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        expire  = 1'b0;
        busy    = !in_idle;
        done    = (state_q == ST_DONE);
        mem_req = (state_q == ST_ACCESS);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    state_d = (!legal || al_misaligned) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                // A ready in the final counted cycle still wins over the timeout.
                if (mem_ready) begin
                    capture = 1'b1;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    expire  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q   <= 1'b0;
            funct3_q     <= 3'b000;
            addr_q       <= 32'h0;
            store_data_q <= 32'h0;
            cnt_q        <= '0;
            load_data_q  <= 32'h0;
            illegal_q    <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            if (accept) begin
                is_store_q   <= is_store;
                funct3_q     <= funct3;
                addr_q       <= addr;
                store_data_q <= store_data;
                cnt_q        <= '0;
                illegal_q    <= !legal;
                misaligned_q <= legal && al_misaligned;
            end
            if (state_q == ST_ACCESS) begin
                cnt_q     <= cnt_q + 1'b1;
                timeout_q <= expire;
                if (capture && !is_store_q) begin
                    load_data_q <= al_load_ext;
                end
            end
            // Fault flags live only for the single DONE cycle.
            if (state_q == ST_DONE) begin
                illegal_q    <= 1'b0;
                misaligned_q <= 1'b0;
                timeout_q    <= 1'b0;
            end
        end
    end

    assign load_data  = load_data_q;
    assign illegal    = illegal_q;
    assign misaligned = misaligned_q;
    assign timeout    = timeout_q;
    assign mem_we     = mem_req && is_store_q;
    assign mem_addr   = {addr_q[31:2], 2'b00};
    assign mem_wmask  = mem_we ? al_wmask : 4'b0000;
    assign mem_wdata  = mem_we ? al_wdata : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, random
// accesses scored against a byte-lane reference model, and a reset abort.
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, store_data;
    logic        busy, done, misaligned, illegal, timeout;
    logic [31:0] load_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;

    int checks = 0;
    int errors = 0;
    logic [31:0] model_load;

    load_store_unit #(.TIMEOUT_CYCLES(T), .CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .store_data (store_data),
        .busy       (busy),
        .done       (done),
        .load_data  (load_data),
        .misaligned (misaligned),
        .illegal    (illegal),
        .timeout    (timeout),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wmask  (mem_wmask),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_store;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        int          delay;     // cycles mem_ready is withheld
        logic        poke;      // re-pulse start while busy
        int          exp_done;  // cycle of done, start sampled in cycle 0
        int          exp_req;   // number of mem_req cycles
        logic [2:0]  exp_flags; // {illegal, misaligned, timeout}
        logic [31:0] exp_load;
        logic [3:0]  exp_wmask;
        logic [31:0] exp_wdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: derives expectations from access size and byte offset.
    function automatic vec_t model(input vec_t v, input logic [31:0] prev_load);
        int size, off;
        logic legal;
        logic [31:0] shifted, val;
        vec_t r = v;
        size  = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        off   = int'(v.addr % 4);
        legal = v.is_store ? (v.f3 <= 3'd2)
                           : (v.f3 == 3'd0 || v.f3 == 3'd1 || v.f3 == 3'd2 || v.f3 == 3'd4 || v.f3 == 3'd5);
        r.exp_load  = prev_load;
        r.exp_flags = 3'b000;
        r.exp_wmask = v.is_store ? 4'(((1 << size) - 1) << off) : 4'h0;
        r.exp_wdata = (size == 1) ? (v.sdata & 32'hFF) * 32'h01010101 :
                      (size == 2) ? (v.sdata & 32'hFFFF) * 32'h00010001 : v.sdata;
        if (!legal) begin
            r.exp_flags = 3'b100; r.exp_done = 1; r.exp_req = 0;
        end else if ((off % size) != 0) begin
            r.exp_flags = 3'b010; r.exp_done = 1; r.exp_req = 0;
        end else if (v.delay < T) begin
            r.exp_done = v.delay + 2;
            r.exp_req  = v.delay + 1;
            if (!v.is_store) begin
                shifted = v.rdata >> (8 * off);
                if (size == 1) begin
                    val = shifted & 32'hFF;
                    if (v.f3 == 3'd0 && val >= 32'd128) val = val - 32'd256;
                end else if (size == 2) begin
                    val = shifted & 32'hFFFF;
                    if (v.f3 == 3'd1 && val >= 32'd32768) val = val - 32'd65536;
                end else begin
                    val = v.rdata;
                end
                r.exp_load = val;
            end
        end else begin
            r.exp_flags = 3'b001; r.exp_done = T + 1; r.exp_req = T;
        end
        return r;
    endfunction

    task automatic apply(input string tag, input vec_t v);
        int req_cnt = 0;
        int done_cyc = -1;
        logic got_done = 1'b0;
        logic stable = 1'b1;
        logic [31:0] a0 = '0, d0 = '0, ld = '0;
        logic [3:0]  m0 = '0;
        logic        we0 = 1'b0;
        logic [2:0]  fl = '0;
        @(negedge clk);
        start = 1'b1; is_store = v.is_store; funct3 = v.f3; addr = v.addr;
        store_data = v.sdata; mem_rdata = v.rdata; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0; is_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom;
        for (int cyc = 1; cyc <= 20 && !got_done; cyc++) begin
            if (done) begin
                got_done = 1'b1; done_cyc = cyc;
                fl = {illegal, misaligned, timeout}; ld = load_data;
            end else begin
                if (mem_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        a0 = mem_addr; we0 = mem_we; m0 = mem_wmask; d0 = mem_wdata;
                    end else if (a0 !== mem_addr || we0 !== mem_we || m0 !== mem_wmask || d0 !== mem_wdata) begin
                        stable = 1'b0;
                    end
                    mem_ready = (req_cnt > v.delay);
                end else begin
                    mem_ready = 1'b0;
                end
                start = v.poke && busy && (cyc == 2);
                @(negedge clk);
            end
        end
        start = 1'b0; mem_ready = 1'b0;
        check({tag, " done_cycle"}, 32'(done_cyc), 32'(v.exp_done));
        check({tag, " flags"}, 32'(fl), 32'(v.exp_flags));
        check({tag, " load_data"}, ld, v.exp_load);
        check({tag, " req_cycles"}, 32'(req_cnt), 32'(v.exp_req));
        if (v.exp_req > 0 && req_cnt > 0) begin
            check({tag, " mem_addr"}, a0, {v.addr[31:2], 2'b00});
            check({tag, " mem_we"}, 32'(we0), 32'(v.is_store));
            check({tag, " mem_wmask"}, 32'(m0), 32'(v.exp_wmask));
            if (v.is_store) check({tag, " mem_wdata"}, d0, v.exp_wdata);
            check({tag, " req_stable"}, 32'(stable), 32'd1);
        end
        @(negedge clk);
        check({tag, " idle_after"}, 32'({busy, done}), 32'd0);
    endtask

    vec_t tbl[13];

    initial begin
        vec_t v;
        logic any_done;
        rst_n = 1'b0; start = 1'b0; is_store = 1'b0; funct3 = 3'b000;
        addr = 32'h0; store_data = 32'h0; mem_rdata = 32'h0; mem_ready = 1'b0;

        //             st    f3    addr          sdata         rdata        dly poke done req flags  load          wmask    wdata
        tbl[0]  = '{1'b1, 3'd0, 32'h0000_1003, 32'h0000_00A5, 32'h0,       0, 1'b0, 2, 1, 3'b000, 32'h0,        4'b1000, 32'hA5A5_A5A5};
        tbl[1]  = '{1'b0, 3'd0, 32'h0000_2002, 32'h0,         32'h1280FF34, 0, 1'b0, 2, 1, 3'b000, 32'hFFFF_FF80, 4'b0000, 32'h0};
        tbl[2]  = '{1'b0, 3'd4, 32'h0000_2002, 32'h0,         32'h1280FF34, 0, 1'b0, 2, 1, 3'b000, 32'h0000_0080, 4'b0000, 32'h0};
        tbl[3]  = '{1'b0, 3'd1, 32'h0000_2002, 32'h0,         32'h1280FF34, 0, 1'b0, 2, 1, 3'b000, 32'h0000_1280, 4'b0000, 32'h0};
        tbl[4]  = '{1'b0, 3'd2, 32'h0000_3001, 32'h0,         32'h0,       0, 1'b0, 1, 0, 3'b010, 32'h0000_1280, 4'b0000, 32'h0};
        tbl[5]  = '{1'b0, 3'd3, 32'h0000_0000, 32'h0,         32'h0,       0, 1'b0, 1, 0, 3'b100, 32'h0000_1280, 4'b0000, 32'h0};
        tbl[6]  = '{1'b0, 3'd2, 32'h0000_4000, 32'h0,         32'hDEADBEEF, 3, 1'b1, 5, 4, 3'b000, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        tbl[7]  = '{1'b0, 3'd2, 32'h0000_4000, 32'h0,         32'h11111111, 6, 1'b0, 5, 4, 3'b001, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        tbl[8]  = '{1'b1, 3'd1, 32'h0000_0006, 32'h1234_ABCD, 32'h0,       1, 1'b0, 3, 2, 3'b000, 32'hDEAD_BEEF, 4'b1100, 32'hABCD_ABCD};
        tbl[9]  = '{1'b0, 3'd6, 32'h0000_0003, 32'h0,         32'h0,       0, 1'b0, 1, 0, 3'b100, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        tbl[10] = '{1'b1, 3'd4, 32'h0000_0000, 32'h0,         32'h0,       0, 1'b0, 1, 0, 3'b100, 32'hDEAD_BEEF, 4'b0000, 32'h0};
        tbl[11] = '{1'b1, 3'd2, 32'h0000_0008, 32'hCAFE_F00D, 32'h0,       2, 1'b1, 4, 3, 3'b000, 32'hDEAD_BEEF, 4'b1111, 32'hCAFE_F00D};
        tbl[12] = '{1'b0, 3'd5, 32'h0000_0002, 32'h0,         32'h80017FFF, 0, 1'b0, 2, 1, 3'b000, 32'h0000_8001, 4'b0000, 32'h0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs",
              32'({busy, done, misaligned, illegal, timeout, mem_req, mem_we, mem_wmask}), 32'd0);
        check("reset_load_data", load_data, 32'h0);
        check("reset_mem_addr", mem_addr | mem_wdata, 32'h0);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end
        model_load = tbl[12].exp_load;

        for (int n = 0; n < 40; n++) begin
            v.is_store = 1'($urandom);
            v.f3       = 3'($urandom);
            v.addr     = $urandom;
            v.sdata    = $urandom;
            v.rdata    = $urandom;
            v.delay    = int'($urandom_range(0, T + 2));
            v.poke     = 1'($urandom);
            v = model(v, model_load);
            apply($sformatf("rand%0d", n), v);
            model_load = v.exp_load;
        end

        // Reset asserted mid-ACCESS must drop mem_req/busy without a clock edge.
        @(negedge clk);
        start = 1'b1; is_store = 1'b0; funct3 = 3'd2; addr = 32'h100; mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("abort_req_before", 32'({mem_req, busy}), 32'd3);
        #2 rst_n = 1'b0;
        #1 check("abort_async_drop", 32'({mem_req, busy}), 32'd0);
        @(negedge clk);
        check("abort_load_cleared", load_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        any_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_done = any_done | done | busy;
        end
        check("abort_no_done", 32'(any_done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the ALU. It consumes the ALU result as the effective byte address for RISC-V RV32I loads and stores.
- Steers byte/halfword/word lanes and generates write masks.
- Runs a request/ready handshake with a word-addressed data memory, then returns sign- or zero-extended load data to writeback.
- Detects misaligned, illegal-width and timed-out accesses. A faulting access never reaches memory, and its `done` cycle reports the fault.

Parameters:
- TIMEOUT_CYCLES, 255: maximum ACCESS cycles without `mem_ready` before the unit aborts with `timeout`. Legal range 1..65535.
- CNT_W, 16: width of the timeout counter. Must satisfy `2^CNT_W > TIMEOUT_CYCLES`.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  one-cycle request from control. Sampled only in IDLE.
- is_store  in  1  1 = store, 0 = load. Latched with `start`.
- funct3  in  3  RV32I width/sign code. Latched with `start`.
- addr  in  32  effective byte address (ALU result). Latched with `start`.
- store_data  in  32  rs2 value. Latched with `start`.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle completion pulse.
- load_data  out  32  extended load result. Valid while `done`=1; holds its value afterwards.
- misaligned  out  1  fault flag, valid with `done`.
- illegal  out  1  fault flag, valid with `done`.
- timeout  out  1  fault flag, valid with `done`.
- mem_req  out  1  memory request, held until accepted.
- mem_we  out  1  write enable, qualified by `mem_req`.
- mem_addr  out  32  word-aligned address: `{addr[31:2], 2'b00}`.
- mem_wmask  out  4  byte-lane write mask. 0 for loads.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read word. Valid in the cycle where `mem_req` and `mem_ready` are both 1.
- mem_ready  in  1  memory completes the transfer in the cycle it is sampled high with `mem_req`.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - All outputs 0, including `load_data`, fault flags and the memory-side outputs.
  - Asserting reset mid-ACCESS drops `mem_req` immediately. No `done` is produced for the aborted access.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - On `start`, latch all inputs.
  - If funct3 is illegal, go to DONE with `illegal`=1.
  - Otherwise, if the access is misaligned, go to DONE with `misaligned`=1.
  - Otherwise go to ACCESS with the counter cleared.
  - When both faults apply, `illegal` takes priority.
- Legal funct3 values:
  - Loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
  - Stores: 000 SB, 001 SH, 010 SW.
  - Every other value is illegal.
- Misalignment rules:
  - Half accesses fault when `addr[0]`=1.
  - Word accesses fault when `addr[1:0]` != 0.
- ACCESS:
  - `mem_req`=1, with `mem_addr`, `mem_we`, `mem_wmask` and `mem_wdata` stable the whole time.
  - When `mem_ready`=1: capture the extracted load data and go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES, drop `mem_req` and go to DONE with `timeout`=1.
  - If `mem_ready` arrives in the same cycle the counter would expire, the access succeeds.
- DONE:
  - `done`=1 for exactly one cycle, `busy`=1, then return to IDLE.
  - Fault flags hold their value only in the DONE cycle.
  - `start` asserted while `busy`=1 is ignored. Control must re-issue it.
- Latency: from `start` sampled in cycle 0, the earliest `done` is cycle 2 (memory ready in cycle 1). A faulting access gives `done` in cycle 1.
- Store lanes:
  - SB: `wdata` = the byte replicated ×4; `wmask` = `4'b0001 << addr[1:0]`.
  - SH: `wdata` = the halfword replicated ×2; `wmask` = 0011 when `addr[1]`=0, 1100 when `addr[1]`=1.
  - SW: `wmask` = 1111.
- Load extraction: byte = `rdata[8*addr[1:0] +: 8]`; half = `rdata[16*addr[1] +: 16]`. Sign-extend for LB/LH, zero-extend for LBU/LHU.
- Faulted access: `load_data` keeps its previous value.

Decomposition:
- Package `lsu_pkg`:
  - funct3 localparams: LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU.
  - State enum `lsu_state_t`.
  - Helper function `lsu_is_legal(is_store, funct3)`.
- One combinational sub-module `lsu_align`:
  - Inputs: funct3, addr[1:0], store_data, rdata.
  - Outputs: wmask, wdata, load_ext, misaligned.
- The FSM, the latch registers and the timeout counter live in `load_store_unit`.

Test Plan:
- SB with store_data=0x000000A5, addr=0x1003, ready in the first ACCESS cycle → mem_addr=0x1000, wmask=1000, wdata=0xA5A5A5A5, mem_we=1, done in cycle 2 with no flags.
- LB and LBU at addr=0x2002 with rdata=0x1280FF34 → LB gives load_data=0xFFFFFF80, LBU gives 0x00000080. LH at 0x2002 gives 0x00001280.
- LW at addr=0x3001 → done in cycle 1 with misaligned=1, mem_req never asserted. funct3=011 → illegal=1.
- LW at 0x4000 with ready withheld for 3 cycles, rdata=0xDEADBEEF → mem_req held 4 cycles with stable outputs, load_data=0xDEADBEEF. A second `start` pulsed during ACCESS is ignored.
- TIMEOUT_CYCLES=4 and no ready → mem_req high for 4 cycles, then done with timeout=1. Ready arriving on the 4th cycle → normal completion.
- rst_n pulsed low mid-ACCESS → mem_req/busy fall without waiting for a clock edge, state returns to IDLE, and no done pulse is produced.
